// File: rtl/fpq_sched_pkg.sv
// Shared definitions for the FPQ output-link scheduler: phase encoding,
// default widths and traffic-class priority codes.
package fpq_sched_pkg;

    localparam int unsigned DEF_CNT_W = 12;
    localparam int unsigned DEF_LEN_W = 8;

    typedef enum logic {
        PH_OPEN = 1'b0,
        PH_WIN  = 1'b1
    } phase_e;

    typedef enum logic [1:0] {
        P_PCF = 2'd0,
        P_TT  = 2'd1,
        P_RC  = 2'd2,
        P_BE  = 2'd3
    } prio_e;

endpackage

// File: rtl/cyclic_slot_counter.sv
// Cyclic slot counter: holds slot 0 until the run flag is up, then counts
// 0..CYCLE_LEN-1 and wraps, flagging the first slot of each period.
module cyclic_slot_counter #(
    parameter int unsigned CNT_W     = 12,
    parameter int unsigned CYCLE_LEN = 1000
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             run_o,
    output logic [CNT_W-1:0] slot_o,
    output logic [CNT_W-1:0] slot_nxt_o,
    output logic             cycle_start_o
);

    localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(CYCLE_LEN - 1);
    localparam logic [CNT_W-1:0] ZERO_SLOT = {CNT_W{1'b0}};

    logic             run_q;
    logic [CNT_W-1:0] slot_q;
    logic [CNT_W-1:0] slot_d;

    // next slot: frozen until running, wraps at the end of the period
    always_comb begin
        slot_d = slot_q;
        if (!run_q) begin
            slot_d = slot_q;
        end else if (slot_q == LAST_SLOT) begin
            slot_d = ZERO_SLOT;
        end else begin
            slot_d = slot_q + CNT_W'(1);
        end
    end

    // run flag and slot register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q  <= 1'b0;
            slot_q <= ZERO_SLOT;
        end else begin
            run_q  <= 1'b1;
            slot_q <= slot_d;
        end
    end

    assign run_o         = run_q;
    assign slot_o        = slot_q;
    assign slot_nxt_o    = slot_d;
    assign cycle_start_o = run_q && (slot_q == ZERO_SLOT);

endmodule

// File: rtl/tt_window_scheduler.sv
// Time-triggered window scheduler for the shared FPQ output link: opens a TT
// window each period and admits low-priority starts only if they end before it.
module tt_window_scheduler
    import fpq_sched_pkg::*;
#(
    parameter int unsigned CNT_W     = DEF_CNT_W,
    parameter int unsigned LEN_W     = DEF_LEN_W,
    parameter int unsigned CYCLE_LEN = 1000,
    parameter int unsigned WIN_START = 600,
    parameter int unsigned WIN_LEN   = 200
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             bool_go_H,
    input  logic [LEN_W-1:0] pkt_len_H,
    input  logic             bool_go_L,
    input  logic [LEN_W-1:0] pkt_len_L,
    output logic             ena_n_H,
    output logic             ena_n_L,
    output logic             link_busy,
    output logic [CNT_W-1:0] slot_cnt,
    output logic             cycle_start,
    output logic             err_overrun
);

    localparam int unsigned      WIN_END = (WIN_START + WIN_LEN) % CYCLE_LEN;
    localparam int unsigned      CMP_W   = (LEN_W > CNT_W + 1) ? LEN_W : CNT_W + 1;
    localparam logic [CNT_W-1:0] WS_SLOT = CNT_W'(WIN_START);
    localparam logic [CNT_W-1:0] WE_SLOT = CNT_W'(WIN_END);
    localparam logic [CNT_W:0]   WS_EXT  = (CNT_W + 1)'(WIN_START);
    localparam logic [CNT_W:0]   CYC_EXT = (CNT_W + 1)'(CYCLE_LEN);
    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);
    localparam logic [LEN_W-1:0] LEN_ZERO = {LEN_W{1'b0}};
    // a window that covers slot 0 must already be open when the schedule (re)starts
    localparam phase_e PH_RESET =
        (((CYCLE_LEN - WIN_START) % CYCLE_LEN) < WIN_LEN) ? PH_WIN : PH_OPEN;

    logic             run_s;
    logic [CNT_W-1:0] slot_nxt_s;
    phase_e           phase_q;
    phase_e           phase_d;
    logic             in_win_s;
    logic [CNT_W:0]   slot_ext_s;
    logic [CNT_W:0]   rem_s;
    logic             len_fits_s;
    logic [LEN_W-1:0] eff_h_s;
    logic [LEN_W-1:0] eff_l_s;
    logic [LEN_W-1:0] busy_q;
    logic [LEN_W-1:0] busy_d;
    logic             err_q;
    logic             err_d;

    cyclic_slot_counter #(
        .CNT_W     (CNT_W),
        .CYCLE_LEN (CYCLE_LEN)
    ) u_slot_cnt (
        .clk           (clk),
        .rst_n         (rst_n),
        .run_o         (run_s),
        .slot_o        (slot_cnt),
        .slot_nxt_o    (slot_nxt_s),
        .cycle_start_o (cycle_start)
    );

    // phase state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= PH_RESET;
        end else begin
            phase_q <= phase_d;
        end
    end

    // phase next state, decided from the slot that is about to be current
    always_comb begin
        phase_d = phase_q;
        case (phase_q)
            PH_OPEN: begin
                if (slot_nxt_s == WS_SLOT) phase_d = PH_WIN;
                else                       phase_d = PH_OPEN;
            end
            PH_WIN: begin
                if (slot_nxt_s == WE_SLOT) phase_d = PH_OPEN;
                else                       phase_d = PH_WIN;
            end
            default: phase_d = PH_RESET;
        endcase
    end

    // phase output decode
    always_comb begin
        in_win_s = 1'b0;
        case (phase_q)
            PH_WIN:  in_win_s = 1'b1;
            PH_OPEN: in_win_s = 1'b0;
            default: in_win_s = 1'b0;
        endcase
    end

    // slots left before the next window opens, current slot included
    always_comb begin
        slot_ext_s = {1'b0, slot_cnt};
        if (slot_ext_s <= WS_EXT) begin
            rem_s = WS_EXT - slot_ext_s;
        end else begin
            rem_s = WS_EXT + CYC_EXT - slot_ext_s;
        end
    end

    assign len_fits_s = (pkt_len_L != LEN_ZERO) && (CMP_W'(pkt_len_L) <= CMP_W'(rem_s));
    assign link_busy  = (busy_q != LEN_ZERO);
    assign ena_n_H    = !(run_s && in_win_s && !link_busy);
    assign ena_n_L    = !(run_s && !in_win_s && !link_busy && len_fits_s);
    assign eff_h_s    = (pkt_len_H == LEN_ZERO) ? LEN_ONE : pkt_len_H;
    assign eff_l_s    = (pkt_len_L == LEN_ZERO) ? LEN_ONE : pkt_len_L;

    // occupancy: any go reloads the remaining-cycle count, otherwise count down
    always_comb begin
        busy_d = busy_q;
        if (bool_go_H && bool_go_L) begin
            busy_d = ((eff_h_s > eff_l_s) ? eff_h_s : eff_l_s) - LEN_ONE;
        end else if (bool_go_H) begin
            busy_d = eff_h_s - LEN_ONE;
        end else if (bool_go_L) begin
            busy_d = eff_l_s - LEN_ONE;
        end else if (busy_q != LEN_ZERO) begin
            busy_d = busy_q - LEN_ONE;
        end else begin
            busy_d = busy_q;
        end
    end

    // sticky protocol-violation flag
    always_comb begin
        err_d = err_q;
        if ((bool_go_H && ena_n_H) || (bool_go_L && ena_n_L) || (bool_go_H && bool_go_L)) begin
            err_d = 1'b1;
        end else begin
            err_d = err_q;
        end
    end

    // occupancy and violation registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= LEN_ZERO;
            err_q  <= 1'b0;
        end else begin
            busy_q <= busy_d;
            err_q  <= err_d;
        end
    end

    assign err_overrun = err_q;

endmodule

// File: tb/tb_tt_window_scheduler.sv
// Scoreboard bench: two schedulers (plain window at 20, wrapped window at 36)
// driven per cycle; a timeline model predicts outputs, a monitor compares them.
module tb_tt_window_scheduler;

    localparam int C  = 40;
    localparam int WL = 8;

    typedef struct {
        int inst;
        int cyc;
        bit ena_h;
        bit ena_l;
        bit busy;
        bit cs;
        bit err;
        int slot;
    } exp_t;

    logic clk;
    logic rst_n;
    logic [1:0]       go_h, go_l, ena_h, ena_l, busy, cs, err;
    logic [1:0][7:0]  len_h, len_l;
    logic [1:0][11:0] slot;

    int   ws [2] = '{20, 36};
    exp_t sb[$];
    exp_t me;
    int   n_chk = 0;
    int   n_err = 0;

    int cyc = 0;
    int rst_last = 0;
    int free_at [2] = '{0, 0};
    bit err_m [2] = '{1'b0, 1'b0};

    bit s_rst = 1'b0;
    bit s_gh [2] = '{1'b0, 1'b0};
    bit s_gl [2] = '{1'b0, 1'b0};
    int s_lh [2] = '{0, 0};
    int s_ll [2] = '{0, 0};

    tt_window_scheduler #(.CNT_W(12), .LEN_W(8), .CYCLE_LEN(C), .WIN_START(20), .WIN_LEN(WL)) u_a (
        .clk(clk), .rst_n(rst_n),
        .bool_go_H(go_h[0]), .pkt_len_H(len_h[0]), .bool_go_L(go_l[0]), .pkt_len_L(len_l[0]),
        .ena_n_H(ena_h[0]), .ena_n_L(ena_l[0]), .link_busy(busy[0]), .slot_cnt(slot[0]),
        .cycle_start(cs[0]), .err_overrun(err[0])
    );

    tt_window_scheduler #(.CNT_W(12), .LEN_W(8), .CYCLE_LEN(C), .WIN_START(36), .WIN_LEN(WL)) u_b (
        .clk(clk), .rst_n(rst_n),
        .bool_go_H(go_h[1]), .pkt_len_H(len_h[1]), .bool_go_L(go_l[1]), .pkt_len_L(len_l[1]),
        .ena_n_H(ena_h[1]), .ena_n_L(ena_l[1]), .link_busy(busy[1]), .slot_cnt(slot[1]),
        .cycle_start(cs[1]), .err_overrun(err[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int eff(int p);
        return (p == 0) ? 1 : p;
    endfunction

    // slot of the cycle about to be driven, or -1 while not running
    function automatic int slot_now();
        if (s_rst && cyc >= rst_last + 2) return (cyc - rst_last - 2) % C;
        return -1;
    endfunction

    // expected outputs from the timeline: run start, window position, link-free time
    function automatic exp_t model(int i);
        exp_t e;
        bit   run, inwin, lb;
        int   s, rem;
        run   = s_rst && (cyc >= rst_last + 2);
        s     = run ? (cyc - rst_last - 2) % C : 0;
        inwin = run && (((s - ws[i] + C) % C) < WL);
        lb    = cyc < free_at[i];
        rem   = (ws[i] - s + C) % C;
        e.inst  = i;
        e.cyc   = cyc;
        e.slot  = s;
        e.busy  = lb;
        e.cs    = run && (s == 0);
        e.err   = err_m[i];
        e.ena_h = !(run && inwin && !lb);
        e.ena_l = !(run && !inwin && !lb && s_ll[i] != 0 && s_ll[i] <= rem);
        return e;
    endfunction

    task automatic step();
        exp_t e;
        int   ph, pl;
        @(posedge clk);
        #2;
        rst_n = s_rst;
        for (int i = 0; i < 2; i++) begin
            go_h[i]  = s_gh[i];
            go_l[i]  = s_gl[i];
            len_h[i] = 8'(s_lh[i]);
            len_l[i] = 8'(s_ll[i]);
        end
        if (!s_rst) rst_last = cyc;
        for (int i = 0; i < 2; i++) begin
            if (!s_rst) begin
                free_at[i] = 0;
                err_m[i]   = 1'b0;
            end
            e = model(i);
            sb.push_back(e);
            if (s_rst) begin
                if ((s_gh[i] && e.ena_h) || (s_gl[i] && e.ena_l) || (s_gh[i] && s_gl[i]))
                    err_m[i] = 1'b1;
                ph = s_gh[i] ? eff(s_lh[i]) : 0;
                pl = s_gl[i] ? eff(s_ll[i]) : 0;
                if (s_gh[i] || s_gl[i]) free_at[i] = cyc + ((ph > pl) ? ph : pl);
            end
            s_gh[i] = 1'b0;
            s_gl[i] = 1'b0;
        end
        cyc++;
    endtask

    task automatic run_to(int target);
        int guard;
        guard = 0;
        while (slot_now() != target && guard < 200) begin
            step();
            guard++;
        end
    endtask

    task automatic chk(string name, int inst, int c, int act, int expv);
        n_chk++;
        if (act != expv) begin
            n_err++;
            $display("FAIL %s inst=%0d cyc=%0d got=%0d exp=%0d", name, inst, c, act, expv);
        end
    endtask

    // monitor: compare every queued expectation against the live outputs
    always @(negedge clk) begin
        while (sb.size() > 0) begin
            me = sb.pop_front();
            chk("ena_n_H",     me.inst, me.cyc, int'(ena_h[me.inst]), int'(me.ena_h));
            chk("ena_n_L",     me.inst, me.cyc, int'(ena_l[me.inst]), int'(me.ena_l));
            chk("link_busy",   me.inst, me.cyc, int'(busy[me.inst]),  int'(me.busy));
            chk("cycle_start", me.inst, me.cyc, int'(cs[me.inst]),    int'(me.cs));
            chk("err_overrun", me.inst, me.cyc, int'(err[me.inst]),   int'(me.err));
            chk("slot_cnt",    me.inst, me.cyc, int'(slot[me.inst]),  me.slot);
        end
    end

    initial begin
        rst_n = 1'b0;
        go_h  = 2'b00;
        go_l  = 2'b00;
        len_h = '0;
        len_l = '0;

        // reset, release, two full periods: guard band on A, wrapped-window fit on B
        s_rst = 1'b0; s_ll = '{5, 32};
        repeat (3) step();
        s_rst = 1'b1;
        repeat (42) step();
        s_ll[1] = 33;
        repeat (40) step();
        s_ll = '{0, 0};
        repeat (40) step();

        // TT start inside the window, running past its end
        s_ll = '{29, 29};
        run_to(21);
        s_gh[0] = 1'b1; s_lh[0] = 10;
        step();
        repeat (15) step();

        // simultaneous go, then go_L inside the window
        s_rst = 1'b0; step(); s_rst = 1'b1;
        run_to(22);
        s_gh[0] = 1'b1; s_lh[0] = 3; s_gl[0] = 1'b1; s_ll[0] = 6;
        step();
        repeat (50) step();
        s_rst = 1'b0; step(); s_rst = 1'b1;
        s_ll[0] = 4;
        run_to(25);
        s_gl[0] = 1'b1;
        step();
        repeat (5) step();

        // reset while the link is busy
        s_rst = 1'b0; step(); s_rst = 1'b1;
        s_ll[0] = 15;
        run_to(2);
        s_gl[0] = 1'b1;
        step();
        run_to(6);
        s_rst = 1'b0; step(); s_rst = 1'b1;
        repeat (12) step();

        // randomized traffic with occasional resets
        for (int n = 0; n < 3000; n++) begin
            s_rst = ($urandom_range(0, 59) != 0);
            for (int i = 0; i < 2; i++) begin
                s_gh[i] = ($urandom_range(0, 9) == 0);
                s_gl[i] = ($urandom_range(0, 9) == 0);
                s_lh[i] = $urandom_range(0, 40);
                s_ll[i] = $urandom_range(0, 40);
            end
            step();
        end

        @(negedge clk);
        #1;
        n_chk++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain got=%0d exp=0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/tt_window_scheduler.md
Name: tt_window_scheduler

Overview:
- Time-triggered window scheduler for the shared FPQ output link.
- Keeps a cyclic slot counter and opens a TT window during which only the high-priority (TT) queue server may start.
- Outside the window it admits low-priority (RC/BE, via round-robin arbiter) starts only if the packet finishes before the next window (guard band).
- Tracks link occupancy from go pulses and flags protocol violations.

Parameters:
- CNT_W, 12, slot counter width.
- LEN_W, 8, packet length width in slots.
- CYCLE_LEN, 12'd1000, schedule period in slots; 2 <= CYCLE_LEN <= 2^CNT_W.
- WIN_START, 12'd600, first slot of TT window; must be < CYCLE_LEN.
- WIN_LEN, 12'd200, TT window length in slots; 1 <= WIN_LEN < CYCLE_LEN.

Ports:
- clk, in, 1: single clock, rising edge.
- rst_n, in, 1: asynchronous, active-low reset.
- bool_go_H, in, 1: TT transmission start pulse, one cycle.
- pkt_len_H, in, LEN_W: length of TT packet, sampled with bool_go_H.
- bool_go_L, in, 1: low-priority start pulse from arbiter, one cycle.
- pkt_len_L, in, LEN_W: length of the candidate low-priority head packet.
- ena_n_H, out, 1: active-low enable to the TT queue server.
- ena_n_L, out, 1: active-low enable to the low-priority arbiter.
- link_busy, out, 1: link occupied by an earlier start.
- slot_cnt, out, CNT_W: current slot.
- cycle_start, out, 1: high while slot_cnt==0 and running.
- err_overrun, out, 1: sticky violation flag.

Behaviour:
- Reset (async, rst_n=0):
  - run=0, slot_cnt=0, busy_cnt=0, err_overrun=0.
  - Outputs: ena_n_H=1, ena_n_L=1, link_busy=0, cycle_start=0.
- Start-up: run sets at the first rising edge after rst_n deasserts. While run==0, both enables are forced 1 and cycle_start=0. slot_cnt stays 0 until run==1, then increments every cycle and wraps CYCLE_LEN-1 -> 0.
- Phase FSM, a registered phase updated with slot_cnt:
  - OPEN -> WIN when the next slot == WIN_START.
  - WIN -> OPEN when the next slot == (WIN_START+WIN_LEN) mod CYCLE_LEN.
  - in_win means phase==WIN; the window may wrap past slot 0.
- rem(s) = (WIN_START - s) mod CYCLE_LEN. Compute it with CNT_W+1 bits, no overflow. It counts slots left before the window, including s.
- Occupancy:
  - A go with length P loads busy_cnt = P-1 at the edge ending the go cycle; the link transmits in the go cycle plus P-1 further cycles.
  - P=0 is treated as P=1.
  - busy_cnt decrements to 0.
  - link_busy = (busy_cnt != 0).
- Enables (combinational from registered state and pkt_len_L):
  - ena_n_H = !(run && in_win && !link_busy).
  - ena_n_L = !(run && !in_win && !link_busy && pkt_len_L != 0 && pkt_len_L <= rem(slot_cnt)).
- A TT start inside the window may run past the window end. The window gates starts only, never aborts a transmission.
- Violations: err_overrun sets at the next edge if any of these occur:
  - bool_go_H while ena_n_H==1;
  - bool_go_L while ena_n_L==1;
  - bool_go_H and bool_go_L in the same cycle.
  - err_overrun clears only on reset.
  - A violating go still loads busy_cnt; on simultaneous go, load the larger length minus 1.
- Reset mid-operation aborts occupancy immediately. The schedule restarts from slot 0 with the start-up rule.

Decomposition:
- Shared package fpq_sched_pkg holds:
  - phase encoding (PH_OPEN=1'b0, PH_WIN=1'b1);
  - default CNT_W/LEN_W;
  - the priority codes P_PCF/P_TT/P_RC/P_BE.
- Sub-module cyclic_slot_counter (run gating, wrap, cycle_start). Occupancy, phase FSM and enables stay in the top module.

Test Plan:
- Bench parameters for all scenarios: CYCLE_LEN=40, WIN_START=20, WIN_LEN=8.
- 1. Reset and wrap: hold rst_n=0 -> all outputs at reset values. Release -> one cycle with run=0, then slot_cnt 0,1,...,39,0. cycle_start is high only at slot 0.
- 2. Guard band: pkt_len_L=5, idle link -> ena_n_L=0 at slot 15 (rem=5) and ena_n_L=1 at slot 16 (rem=4) through slot 27. pkt_len_L=0 -> ena_n_L=1 everywhere.
- 3. TT window: ena_n_H=0 at slots 20..27 only. bool_go_H at slot 21 with pkt_len_H=10 -> link_busy high at slots 22..30, ena_n_H=1 from slot 22. ena_n_L returns 0 at slot 31 for pkt_len_L<=29.
- 4. Violations: simultaneous go_H/go_L at slot 22 -> err_overrun=1 next cycle, held until reset. Separately, go_L at slot 25 -> err_overrun=1.
- 5. Wrapped window (WIN_START=36): ena_n_H=0 at slots 36..39 and 0..3. At slot 4, pkt_len_L=32 -> ena_n_L=0; pkt_len_L=33 -> ena_n_L=1.
- 6. Reset mid-busy: go_L with pkt_len_L=15 at slot 2, rst_n low at slot 6 -> link_busy=0 and err_overrun=0 immediately. After release the start-up sequence repeats from slot 0.
